bcd_add_datapath: RTL and testbench
===================================

BCD_ADD_DATAPATH -- requirements
Module: bcd_add_datapath

Interface
REQ-001 SHALL have no parameters; operand width is fixed at two BCD digits (8 bits).
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RESET  input  1  reset, synchronous and active-high.
REQ-004 DATA_IN  input  8  operand source from switches, {tens digit, units digit}.
REQ-005 BCD_INIT / BCD_INIT_ACK  input / output  1 / 1  clear-all handshake.
REQ-006 BCD_LOAD_A / BCD_LOAD_A_ACK  input / output  1 / 1  latch DATA_IN into A.
REQ-007 BCD_LOAD_B / BCD_LOAD_B_ACK  input / output  1 / 1  latch DATA_IN into B.
REQ-008 BCD_DISPLAY_A / BCD_DISPLAY_A_ACK  input / output  1 / 1  show A.
REQ-009 BCD_DISPLAY_B / BCD_DISPLAY_B_ACK  input / output  1 / 1  show B.
REQ-010 BCD_ADD / BCD_ADD_ACK  input / output  1 / 1  compute R = A + B.
REQ-011 BCD_DISPLAY_RESULT_LS / BCD_DISPLAY_RESULT_LS_ACK  input / output  1 / 1  show R[7:0].
REQ-012 BCD_DISPLAY_RESULT_MS / BCD_DISPLAY_RESULT_MS_ACK  input / output  1 / 1  show {4'h0, R[11:8]}.
REQ-013 LED  output  8  registered display value.
REQ-014 BCD_ERROR  output  1  sticky flag for an invalid BCD load.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, ADD_D0, ADD_D1, ACK.
REQ-016 Internal registers SHALL be A[7:0], B[7:0], R[11:0], carry C, and a 3-bit op code holding the accepted request.
REQ-017 In IDLE, if any request is high, the FSM SHALL accept exactly one, by priority INIT > LOAD_A > LOAD_B > ADD > DISPLAY_A > DISPLAY_B > RESULT_LS > RESULT_MS.
REQ-018 Non-ADD ops SHALL execute on the accepting edge, go to ACK, and assert their own ack; the ack is therefore visible the cycle after the request is first sampled.
REQ-019 Op actions:
- INIT clears A, B, R, LED and BCD_ERROR.
- LOAD_A / LOAD_B latch DATA_IN.
- DISPLAY_A / DISPLAY_B set LED to A / B.
- RESULT_LS sets LED to R[7:0].
- RESULT_MS sets LED to {4'h0, R[11:8]}.
REQ-020 ADD SHALL proceed one digit per cycle:
- On the accepting edge: go to ADD_D0 and clear C.
- ADD_D0: s = A[3:0] + B[3:0]; if s > 9, R[3:0] = s + 6 (mod 16) and C = 1, else R[3:0] = s and C = 0.
- ADD_D1: the same rule on A[7:4] + B[7:4] + C into R[7:4]; R[11:8] = final carry (0 or 1); go to ACK and assert BCD_ADD_ACK.
- Ack latency: 3 cycles after the request is first sampled.
REQ-021 ADD SHALL NOT modify LED.
REQ-022 In ACK, only the ack of the stored op SHALL be high; it SHALL stay high until the stored op's request is sampled low, then drop on that edge with a return to IDLE.
REQ-023 Other requests that are high while in ACK SHALL be ignored until IDLE.
REQ-024 Each request-high period SHALL execute its op exactly once.
REQ-025 Requests arriving during ADD_D0/ADD_D1 SHALL be held off; no acks are emitted.
REQ-026 At most one ack SHALL be high in any cycle.

Reset
REQ-027 While RESET is high at a clock edge, the block SHALL set: state IDLE, all acks 0, A = B = 0, R = 0, C = 0, LED = 0, BCD_ERROR = 0.
REQ-028 RESET SHALL have no asynchronous effect.
REQ-029 RESET asserted mid-ADD or in ACK SHALL abort the op with no ack issued.
REQ-030 After reset, a request still held high SHALL be accepted afresh.

Configuration
REQ-031 With BCD_INPUT_CHECK_EN defined, a LOAD_A/LOAD_B where either DATA_IN nibble > 9 SHALL load 8'h00, set BCD_ERROR (sticky until INIT or RESET), and still ack normally.
REQ-032 Without BCD_INPUT_CHECK_EN, DATA_IN SHALL load unchecked and BCD_ERROR SHALL be constant 0.

Verification
REQ-033 Reset, then DATA_IN=8'h47 with LOAD_A held until ack -> BCD_LOAD_A_ACK rises 1 cycle after the request is sampled, stays high until the request drops, A=8'h47.
REQ-034 A=8'h99, B=8'h99, ADD -> ack exactly 3 cycles after the request is sampled; RESULT_LS gives LED=8'h98; RESULT_MS gives LED=8'h01.
REQ-035 A=8'h25, B=8'h14, ADD then RESULT_LS -> LED=8'h39; RESULT_MS -> LED=8'h00.
REQ-036 LOAD_B and DISPLAY_A raised in the same cycle -> LOAD_B acked first; DISPLAY_A accepted only after LOAD_B drops; never two acks high together.
REQ-037 RESET pulsed in ADD_D1 -> no BCD_ADD_ACK, R=0, state IDLE; ADD still high after reset -> re-executed and acked.
REQ-038 With BCD_INPUT_CHECK_EN, LOAD_A with DATA_IN=8'h3C -> A=8'h00, BCD_ERROR=1 until INIT; without the macro -> A=8'h3C, BCD_ERROR=0.

Source files
------------

// File: rtl/bcd_add_datapath_if.sv
// rtl/bcd_add_datapath_if.sv - request/acknowledge handshake bundle for bcd_add_datapath
// One request/ack pair per operation; the requester drives requests, the datapath drives acks.
interface bcd_add_datapath_if;
    logic bcd_init;
    logic bcd_init_ack;
    logic bcd_load_a;
    logic bcd_load_a_ack;
    logic bcd_load_b;
    logic bcd_load_b_ack;
    logic bcd_display_a;
    logic bcd_display_a_ack;
    logic bcd_display_b;
    logic bcd_display_b_ack;
    logic bcd_add;
    logic bcd_add_ack;
    logic bcd_display_result_ls;
    logic bcd_display_result_ls_ack;
    logic bcd_display_result_ms;
    logic bcd_display_result_ms_ack;

    modport master (
        output bcd_init, bcd_load_a, bcd_load_b, bcd_display_a, bcd_display_b,
               bcd_add, bcd_display_result_ls, bcd_display_result_ms,
        input  bcd_init_ack, bcd_load_a_ack, bcd_load_b_ack, bcd_display_a_ack,
               bcd_display_b_ack, bcd_add_ack, bcd_display_result_ls_ack,
               bcd_display_result_ms_ack
    );

    modport slave (
        input  bcd_init, bcd_load_a, bcd_load_b, bcd_display_a, bcd_display_b,
               bcd_add, bcd_display_result_ls, bcd_display_result_ms,
        output bcd_init_ack, bcd_load_a_ack, bcd_load_b_ack, bcd_display_a_ack,
               bcd_display_b_ack, bcd_add_ack, bcd_display_result_ls_ack,
               bcd_display_result_ms_ack
    );
endinterface

// File: rtl/bcd_add_datapath.sv
// rtl/bcd_add_datapath.sv - two-digit BCD adder datapath with 4-phase request/ack control
// Optional input digit checking on loads is enabled by defining BCD_INPUT_CHECK_EN.
module bcd_add_datapath (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         data_in_i,
    bcd_add_datapath_if.slave  bus,
    output logic [7:0]         led_o,
    output logic               bcd_error_o
);
    typedef enum logic [1:0] {IDLE, ADD_D0, ADD_D1, ACK} state_e;

    // Op codes double as priority rank and as the ack bit index.
    localparam logic [2:0] OP_INIT   = 3'd0;
    localparam logic [2:0] OP_LOAD_A = 3'd1;
    localparam logic [2:0] OP_LOAD_B = 3'd2;
    localparam logic [2:0] OP_ADD    = 3'd3;
    localparam logic [2:0] OP_DISP_A = 3'd4;
    localparam logic [2:0] OP_DISP_B = 3'd5;
    localparam logic [2:0] OP_RES_LS = 3'd6;
    localparam logic [2:0] OP_RES_MS = 3'd7;

    state_e      state_q;
    logic [2:0]  op_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [11:0] r_q;
    logic        c_q;
    logic [7:0]  led_q;
    logic [7:0]  ack_q;

    logic [7:0]  req;
    logic        req_any;
    logic [2:0]  grant_d;
    logic [4:0]  lo_d;
    logic [4:0]  hi_d;

    function automatic logic [4:0] bcd_digit(input logic [4:0] s);
        if (s > 5'd9) begin
            return {1'b1, s[3:0] + 4'd6};
        end
        return {1'b0, s[3:0]};
    endfunction

`ifdef BCD_INPUT_CHECK_EN
    function automatic logic bad_bcd(input logic [7:0] d);
        return (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
    endfunction

    function automatic logic [7:0] load_value(input logic [7:0] d);
        return bad_bcd(d) ? 8'h00 : d;
    endfunction
`else
    function automatic logic [7:0] load_value(input logic [7:0] d);
        return d;
    endfunction
`endif

    assign req = {bus.bcd_display_result_ms, bus.bcd_display_result_ls,
                  bus.bcd_display_b, bus.bcd_display_a, bus.bcd_add,
                  bus.bcd_load_b, bus.bcd_load_a, bus.bcd_init};
    assign req_any = |req;

    always_comb begin
        grant_d = OP_INIT;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                grant_d = i[2:0];
            end
        end
    end

    assign lo_d = bcd_digit({1'b0, a_q[3:0]} + {1'b0, b_q[3:0]});
    assign hi_d = bcd_digit({1'b0, a_q[7:4]} + {1'b0, b_q[7:4]} + {4'b0000, c_q});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_INIT;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            r_q     <= 12'h000;
            c_q     <= 1'b0;
            led_q   <= 8'h00;
            ack_q   <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        op_q <= grant_d;
                        case (grant_d)
                            OP_INIT: begin
                                a_q   <= 8'h00;
                                b_q   <= 8'h00;
                                r_q   <= 12'h000;
                                led_q <= 8'h00;
                            end
                            OP_LOAD_A: a_q   <= load_value(data_in_i);
                            OP_LOAD_B: b_q   <= load_value(data_in_i);
                            OP_ADD:    c_q   <= 1'b0;
                            OP_DISP_A: led_q <= a_q;
                            OP_DISP_B: led_q <= b_q;
                            OP_RES_LS: led_q <= r_q[7:0];
                            OP_RES_MS: led_q <= {4'h0, r_q[11:8]};
                            default:   led_q <= led_q;
                        endcase
                        if (grant_d == OP_ADD) begin
                            state_q <= ADD_D0;
                        end else begin
                            state_q <= ACK;
                            ack_q   <= 8'h01 << grant_d;
                        end
                    end
                end
                ADD_D0: begin
                    r_q[3:0] <= lo_d[3:0];
                    c_q      <= lo_d[4];
                    state_q  <= ADD_D1;
                end
                ADD_D1: begin
                    r_q[7:4]  <= hi_d[3:0];
                    r_q[11:8] <= {3'b000, hi_d[4]};
                    c_q       <= hi_d[4];
                    ack_q     <= 8'h01 << OP_ADD;
                    state_q   <= ACK;
                end
                ACK: begin
                    // Hold the ack until this op's own request is released.
                    if (!req[op_q]) begin
                        ack_q   <= 8'h00;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BCD_INPUT_CHECK_EN
    logic err_q;
    logic accept_d;

    assign accept_d = (state_q == IDLE) && req_any;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept_d && grant_d == OP_INIT) begin
            err_q <= 1'b0;
        end else if (accept_d && (grant_d == OP_LOAD_A || grant_d == OP_LOAD_B)
                     && bad_bcd(data_in_i)) begin
            err_q <= 1'b1;
        end
    end

    assign bcd_error_o = err_q;
`else
    assign bcd_error_o = 1'b0;
`endif

    assign led_o = led_q;

    assign bus.bcd_init_ack              = ack_q[0];
    assign bus.bcd_load_a_ack            = ack_q[1];
    assign bus.bcd_load_b_ack            = ack_q[2];
    assign bus.bcd_add_ack               = ack_q[3];
    assign bus.bcd_display_a_ack         = ack_q[4];
    assign bus.bcd_display_b_ack         = ack_q[5];
    assign bus.bcd_display_result_ls_ack = ack_q[6];
    assign bus.bcd_display_result_ms_ack = ack_q[7];
endmodule

// File: tb/tb_bcd_add_datapath.sv
// tb/tb_bcd_add_datapath.sv - scoreboard bench for bcd_add_datapath
module tb_bcd_add_datapath;
    localparam int OP_INIT   = 0;
    localparam int OP_LOAD_A = 1;
    localparam int OP_LOAD_B = 2;
    localparam int OP_ADD    = 3;
    localparam int OP_DISP_A = 4;
    localparam int OP_DISP_B = 5;
    localparam int OP_RES_LS = 6;
    localparam int OP_RES_MS = 7;

    logic       clk;
    logic       rst;
    logic [7:0] data_v;
    logic [7:0] req_v;
    logic [7:0] ack_v;
    logic [7:0] led;
    logic       err;

    int n_checks;
    int n_pass;

    logic [7:0]  a_m;
    logic [7:0]  b_m;
    logic [11:0] r_m;
    logic [7:0]  led_m;
    logic        err_m;
    logic [7:0]  sb_q[$];

    bcd_add_datapath_if bus ();

    assign bus.bcd_init              = req_v[0];
    assign bus.bcd_load_a            = req_v[1];
    assign bus.bcd_load_b            = req_v[2];
    assign bus.bcd_add               = req_v[3];
    assign bus.bcd_display_a         = req_v[4];
    assign bus.bcd_display_b         = req_v[5];
    assign bus.bcd_display_result_ls = req_v[6];
    assign bus.bcd_display_result_ms = req_v[7];
    assign ack_v = {bus.bcd_display_result_ms_ack, bus.bcd_display_result_ls_ack,
                    bus.bcd_display_b_ack, bus.bcd_display_a_ack, bus.bcd_add_ack,
                    bus.bcd_load_b_ack, bus.bcd_load_a_ack, bus.bcd_init_ack};

    bcd_add_datapath dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_in_i   (data_v),
        .bus         (bus),
        .led_o       (led),
        .bcd_error_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [11:0] int2bcd(input int x);
        logic [11:0] r;
        r[11:8] = 4'(x / 100);
        r[7:4]  = 4'((x / 10) % 10);
        r[3:0]  = 4'(x % 10);
        return r;
    endfunction

    function automatic logic [7:0] model_load(input logic [7:0] d);
`ifdef BCD_INPUT_CHECK_EN
        if (d[7:4] > 4'd9 || d[3:0] > 4'd9) begin
            err_m = 1'b1;
            return 8'h00;
        end
`endif
        return d;
    endfunction

    task automatic model_exec(input int op);
        case (op)
            OP_INIT: begin
                a_m = 8'h00; b_m = 8'h00; r_m = 12'h000; led_m = 8'h00; err_m = 1'b0;
            end
            OP_LOAD_A: a_m = model_load(data_v);
            OP_LOAD_B: b_m = model_load(data_v);
            OP_ADD:    r_m = int2bcd(bcd2int(a_m) + bcd2int(b_m));
            OP_DISP_A: led_m = a_m;
            OP_DISP_B: led_m = b_m;
            OP_RES_LS: led_m = r_m[7:0];
            default:   led_m = {4'h0, r_m[11:8]};
        endcase
    endtask

    // Raise a request, wait for its ack, compare against the scoreboard, then release.
    task automatic do_op(input int op, input int hold);
        int n;
        int lat;
        bit seen;
        logic [7:0] exp_led;
        lat  = (op == OP_ADD) ? 3 : 1;
        n    = 0;
        seen = 1'b0;
        req_v[op] = 1'b1;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            if (ack_v != 8'h00) seen = 1'b1;
        end
        check("ack_latency", n, lat);
        check("ack_onehot", ack_v, 8'h01 << op);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            exp_led = sb_q.pop_front();
            check("led", led, exp_led);
        end
        check("bcd_error", err, err_m);
        repeat (hold) begin
            @(negedge clk);
            check("ack_hold", ack_v, 8'h01 << op);
        end
        req_v[op] = 1'b0;
        @(negedge clk);
        check("ack_drop", ack_v, 8'h00);
    endtask

    task automatic run_op(input int op, input int hold);
        model_exec(op);
        sb_q.push_back(led_m);
        do_op(op, hold);
    endtask

    task automatic add_case(input logic [7:0] a, input logic [7:0] b);
        data_v = a; run_op(OP_LOAD_A, 0);
        data_v = b; run_op(OP_LOAD_B, 0);
        run_op(OP_ADD, 1);
        run_op(OP_RES_LS, 0);
        run_op(OP_RES_MS, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        req_v    = 8'h00;
        data_v   = 8'h00;
        a_m = 8'h00; b_m = 8'h00; r_m = 12'h000; led_m = 8'h00; err_m = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_led", led, 8'h00);
        check("reset_err", err, 1'b0);
        check("reset_ack", ack_v, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        data_v = 8'h47;
        run_op(OP_LOAD_A, 3);
        run_op(OP_DISP_A, 0);

        add_case(8'h99, 8'h99);
        add_case(8'h25, 8'h14);
        add_case(8'h00, 8'h00);
        add_case(8'h50, 8'h50);
        for (int i = 0; i < 5; i++) begin
            add_case({4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))},
                     {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))});
        end
        run_op(OP_DISP_B, 0);

        // Simultaneous LOAD_B and DISPLAY_A: LOAD_B wins, DISPLAY_A waits for IDLE.
        data_v = 8'h12;
        req_v[OP_LOAD_B] = 1'b1;
        req_v[OP_DISP_A] = 1'b1;
        model_exec(OP_LOAD_B);
        @(negedge clk);
        check("prio_first", ack_v, 8'h04);
        repeat (2) begin
            @(negedge clk);
            check("prio_hold", ack_v, 8'h04);
        end
        req_v[OP_LOAD_B] = 1'b0;
        @(negedge clk);
        check("prio_drop", ack_v, 8'h00);
        model_exec(OP_DISP_A);
        @(negedge clk);
        check("prio_second", ack_v, 8'h10);
        check("prio_led", led, led_m);
        req_v[OP_DISP_A] = 1'b0;
        @(negedge clk);
        check("prio_release", ack_v, 8'h00);
        run_op(OP_DISP_B, 0);

        // Reset while in ADD_D1 aborts the add; the still-high request reruns afterwards.
        data_v = 8'h58; run_op(OP_LOAD_A, 0);
        data_v = 8'h67; run_op(OP_LOAD_B, 0);
        req_v[OP_ADD] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_add_ack", ack_v, 8'h00);
        check("rst_mid_add_led", led, 8'h00);
        @(negedge clk);
        check("rst_hold_ack", ack_v, 8'h00);
        rst = 1'b0;
        a_m = 8'h00; b_m = 8'h00; r_m = 12'h000; led_m = 8'h00; err_m = 1'b0;
        run_op(OP_ADD, 0);
        run_op(OP_RES_LS, 0);
        run_op(OP_RES_MS, 0);

        // Non-BCD load: checked build zeroes it and flags, plain build passes it through.
        data_v = 8'h3C;
        run_op(OP_LOAD_A, 1);
        run_op(OP_DISP_A, 0);
        data_v = 8'h21;
        run_op(OP_LOAD_B, 0);
        run_op(OP_DISP_B, 0);
        run_op(OP_INIT, 0);
        run_op(OP_DISP_A, 0);
        run_op(OP_RES_LS, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
